// File: rtl/frontier_test_mem_pkg.sv
// Shared defaults, master indices and types for the two-master RAM arbiter.
package frontier_test_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic {
    MASTER_M0 = 1'b0,
    MASTER_M1 = 1'b1
  } master_e;

  // Read-return tracking: a read issued this cycle returns data next cycle.
  typedef struct packed {
    logic    valid;
    master_e owner;
  } rd_track_t;

  // One-hot two-way round-robin pick: on contention the master that did
  // not win most recently gets the grant; a lone requester always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input master_e last);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (last == MASTER_M1) gnt = 2'b01;
      else                   gnt = 2'b10;
    end else begin
      gnt = req;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/frontier_rr_arb2.sv
// Two-requester round-robin arbiter; the history only moves when an access issues.
module frontier_rr_arb2
  import frontier_test_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       issue,
  output logic [1:0] gnt
);

  master_e last_grant;

  // Remember who won the last issued access; reset favours m0 next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= MASTER_M1;
    end else if (issue) begin
      last_grant <= master_e'(gnt[M1]);
    end
  end

  // Grant is purely combinational in the request cycle.
  always_comb begin
    gnt = rr_pick(req, last_grant);
  end

endmodule

// File: rtl/frontier_test_mem_arbiter.sv
// Shares one single-port RAM (registered address, unregistered output)
// between two Avalon-style masters with round-robin arbitration.
module frontier_test_mem_arbiter
  import frontier_test_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       issue;
  logic       read_accepted;
  rd_track_t  rd_track;

  // A master requests on read or write; nothing is arbitrated in reset.
  always_comb begin
    req[M0] = m0_read | m0_write;
    req[M1] = m1_read | m1_write;
    arb_req = reset ? 2'b00 : req;
  end

  frontier_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .issue (issue),
    .gnt   (gnt)
  );

  // Steer the winner onto the RAM port; write beats read within a master,
  // and reads always enable every byte lane.
  always_comb begin
    issue          = |gnt;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (gnt[M0]) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
      mem_writedata  = m0_writedata;
    end else if (gnt[M1]) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
      mem_writedata  = m1_writedata;
    end
    read_accepted  = issue & ~mem_write;
    mem_clken      = ~reset;
    m0_waitrequest = req[M0] & ~gnt[M0];
    m1_waitrequest = req[M1] & ~gnt[M1];
  end

  // Track the single outstanding read so its data is routed back next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_track <= '{valid: 1'b0, owner: MASTER_M0};
    end else begin
      rd_track.valid <= read_accepted;
      rd_track.owner <= master_e'(gnt[M1]);
    end
  end

  // Return data straight from the RAM; a reset in the return cycle kills the beat.
  always_comb begin
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = ~reset & rd_track.valid & (rd_track.owner == MASTER_M0);
    m1_readdatavalid = ~reset & rd_track.valid & (rd_track.owner == MASTER_M1);
  end

endmodule

// File: tb/tb_frontier_test_mem_arbiter.sv
// Randomised and directed check of the two-master RAM arbiter against a
// transaction-level model (round-robin rule plus shadow memory).
module tb_frontier_test_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frontier_test_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Single-port RAM with registered address and unregistered output.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ram_addr_q = '0;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model state: who won last, shadow contents, read in flight.
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  int                m_last = 1;
  bit                pend_valid = 0;
  int                pend_owner = 0;
  logic [DATA_W-1:0] pend_data = '0;

  // Observations from the most recent cycle for directed constant checks.
  logic              obs_wr0, obs_wr1, obs_v0, obs_v1;
  logic [DATA_W-1:0] obs_rd0, obs_rd1;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic applyStimulus(
    input logic rst,
    input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
    input logic [BE_W-1:0] be0, input logic [DATA_W-1:0] d0,
    input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
    input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1);
    bit req0, req1, gw, exp_v0, exp_v1;
    int g;
    logic [ADDR_W-1:0] ga;
    logic [BE_W-1:0] gbe;
    logic [DATA_W-1:0] gd;
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #1;
    req0 = r0 | w0;
    req1 = r1 | w1;
    g = -1;
    if (!rst) begin
      if (req0 && req1) g = (m_last == 1) ? 0 : 1;
      else if (req0)    g = 0;
      else if (req1)    g = 1;
    end
    gw  = (g == 0) ? w0 : w1;
    ga  = (g == 0) ? a0 : a1;
    gbe = (g == 0) ? be0 : be1;
    gd  = (g == 0) ? d0 : d1;
    exp_v0 = !rst && pend_valid && pend_owner == 0;
    exp_v1 = !rst && pend_valid && pend_owner == 1;

    checkOutput("m0_waitrequest", m0_waitrequest, req0 && g != 0);
    checkOutput("m1_waitrequest", m1_waitrequest, req1 && g != 1);
    checkOutput("mem_chipselect", mem_chipselect, g >= 0);
    checkOutput("mem_write", mem_write, g >= 0 && gw);
    checkOutput("mem_clken", mem_clken, !rst);
    checkOutput("m0_readdatavalid", m0_readdatavalid, exp_v0);
    checkOutput("m1_readdatavalid", m1_readdatavalid, exp_v1);
    if (exp_v0) checkOutput("m0_readdata", m0_readdata, pend_data);
    if (exp_v1) checkOutput("m1_readdata", m1_readdata, pend_data);
    if (g >= 0) begin
      checkOutput("mem_address", mem_address, ga);
      checkOutput("mem_byteenable", mem_byteenable, gw ? gbe : 4'hF);
      if (gw) checkOutput("mem_writedata", mem_writedata, gd);
    end
    obs_wr0 = m0_waitrequest; obs_wr1 = m1_waitrequest;
    obs_v0 = m0_readdatavalid; obs_v1 = m1_readdatavalid;
    obs_rd0 = m0_readdata; obs_rd1 = m1_readdata;

    if (rst) begin
      m_last = 1;
      pend_valid = 0;
    end else if (g >= 0) begin
      m_last = g;
      if (gw) begin
        for (int b = 0; b < BE_W; b++)
          if (gbe[b]) shadow[ga][8*b +: 8] = gd[8*b +: 8];
        pend_valid = 0;
      end else begin
        pend_valid = 1;
        pend_owner = g;
        pend_data  = shadow[ga];
      end
    end else begin
      pend_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end

    // Reset with requests pending: waitrequest mirrors request, nothing issued.
    idle(1);
    applyStimulus(1, 1, 0, 10'h001, 4'hF, '0, 0, 1, 10'h002, 4'hF, 32'h1);
    checkOutput("rst_wait_m0", obs_wr0, 1);
    checkOutput("rst_wait_m1", obs_wr1, 1);

    // Full write then read-back on m0.
    applyStimulus(0, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0);
    applyStimulus(0, 1, 0, 10'h005, 4'h0, '0, 0, 0, '0, '0, '0);
    idle(0);
    checkOutput("wr_rd_valid0", obs_v0, 1);
    checkOutput("wr_rd_valid1", obs_v1, 0);
    checkOutput("wr_rd_data", obs_rd0, 32'hDEADBEEF);

    // Byte-lane merge.
    applyStimulus(0, 0, 1, 10'h010, 4'hF, 32'h11223344, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, 1, 10'h010, 4'h2, 32'h0000AA00, 0, 0, '0, '0, '0);
    applyStimulus(0, 1, 0, 10'h010, 4'h0, '0, 0, 0, '0, '0, '0);
    idle(0);
    checkOutput("merge_data", obs_rd0, 32'h1122AA44);

    // Contention after reset alternates m0, m1, m0, m1.
    idle(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 10'h005, '0, '0, 1, 0, 10'h010, '0, '0);
      checkOutput("rr_wait_m0", obs_wr0, (i % 2) == 1);
      checkOutput("rr_wait_m1", obs_wr1, (i % 2) == 0);
      if (i > 0) checkOutput("rr_valid_m0", obs_v0, (i % 2) == 1);
    end
    idle(0);
    checkOutput("rr_last_valid_m1", obs_v1, 1);
    checkOutput("rr_last_data", obs_rd1, 32'h1122AA44);

    // Reset right after an accepted read swallows the return beat.
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 0, 10'h3FF, '0, '0);
    idle(1);
    checkOutput("rst_kill_valid1", obs_v1, 0);
    applyStimulus(0, 1, 0, 10'h001, '0, '0, 1, 0, 10'h002, '0, '0);
    checkOutput("post_rst_m0_wins", obs_wr0, 0);
    idle(0);

    // Read and write together is a write.
    applyStimulus(0, 1, 1, 10'h020, 4'hF, 32'h5A5A5A5A, 0, 0, '0, '0, '0);
    idle(0);
    checkOutput("rw_no_valid", obs_v0, 0);
    applyStimulus(0, 1, 0, 10'h020, '0, '0, 0, 0, '0, '0, '0);
    idle(0);
    checkOutput("rw_data", obs_rd0, 32'h5A5A5A5A);

    // m1 streams eight reads with m0 idle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, '0, '0, '0, 1, 0, ADDR_W'(i * 4 + 1), '0, '0);
      checkOutput("stream_wait_m1", obs_wr1, 0);
      if (i > 0) checkOutput("stream_valid_m1", obs_v1, 1);
    end
    idle(0);
    checkOutput("stream_last_valid", obs_v1, 1);

    // Random traffic over a small address window with occasional reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
                    BE_W'($urandom), $urandom,
                    1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
                    BE_W'($urandom), $urandom);
    end
    idle(0);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
